// File: rtl/ask4_upsample_src.sv
`default_nettype none
// ============================================================================
// Module   : ask4_upsample_src
// Function : clk/4 and clk/16 enables, LFSR-driven 4-ASK symbols, x4 zero-stuffed
//            upsampling into the pulse-shaping FIR. Optional: IMPULSE_MODE_EN.
// Revision : 1.0
// ============================================================================
module ask4_upsample_src #(
  parameter logic [21:0]        LFSR_SEED      = 22'h3FFFFF,
  parameter logic signed [17:0] MAG_A          = 18'sd32768,
  parameter int                 IMPULSE_PERIOD = 32
) (
  input  logic               clk,
  input  logic               reset,
`ifdef IMPULSE_MODE_EN
  input  logic               impulse_sel,
`endif
  output logic               sam_clk_en,
  output logic               sym_clk_en,
  output logic signed [17:0] x_out,
  output logic [1:0]         sym_out,
  output logic [21:0]        lfsr_state
);

  localparam int MAG_I = int'(MAG_A);
  localparam int P1_I  = MAG_I;
  localparam int P3_I  = 3 * MAG_I;
  localparam int M1_I  = -P1_I;
  localparam int M3_I  = -P3_I;
  localparam logic signed [17:0] LVL_P1 = P1_I[17:0];
  localparam logic signed [17:0] LVL_P3 = P3_I[17:0];
  localparam logic signed [17:0] LVL_M1 = M1_I[17:0];
  localparam logic signed [17:0] LVL_M3 = M3_I[17:0];

  generate
    if (LFSR_SEED == 22'd0 || IMPULSE_PERIOD < 21 || P3_I > 131071) begin : g_param_check
      $error("ask4_upsample_src: illegal parameter set");
    end
  endgenerate

  function automatic logic signed [17:0] map_level(input logic [1:0] s);
    case (s)
      2'b00:   map_level = LVL_M3;
      2'b01:   map_level = LVL_M1;
      2'b10:   map_level = LVL_P1;
      default: map_level = LVL_P3;
    endcase
  endfunction

  logic [3:0]         cnt_q,  cnt_d;
  logic signed [17:0] x_q,    x_d;
  logic [1:0]         sym_q,  sym_d;
  logic [21:0]        lfsr_q, lfsr_d;
  logic [21:0]        lfsr_nxt;

`ifdef IMPULSE_MODE_EN
  localparam int SC_W = (IMPULSE_PERIOD > 1) ? $clog2(IMPULSE_PERIOD) : 1;
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(IMPULSE_PERIOD - 1);
  logic [SC_W-1:0] sc_q, sc_d;
`endif

  // A zero state can only arise from an upset; recover by reloading the seed.
  assign lfsr_nxt = (lfsr_q == 22'd0) ? LFSR_SEED
                                      : {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[20]};

  always_comb begin
    cnt_d  = cnt_q + 4'd1;
    x_d    = x_q;
    sym_d  = sym_q;
    lfsr_d = lfsr_q;
`ifdef IMPULSE_MODE_EN
    sc_d   = sc_q;
`endif
    if (cnt_q == 4'd14) begin
`ifdef IMPULSE_MODE_EN
      if (impulse_sel) begin
        if (sc_q == '0) begin
          x_d   = LVL_P3;
          sym_d = 2'b11;
        end else begin
          x_d   = '0;
          sym_d = 2'b00;
        end
        sc_d = (sc_q == SC_MAX) ? '0 : sc_q + 1'b1;
      end else begin
        sc_d   = '0;
        sym_d  = lfsr_q[1:0];
        x_d    = map_level(lfsr_q[1:0]);
        lfsr_d = lfsr_nxt;
      end
`else
      sym_d  = lfsr_q[1:0];
      x_d    = map_level(lfsr_q[1:0]);
      lfsr_d = lfsr_nxt;
`endif
    end else if (cnt_q[1:0] == 2'd2) begin
      x_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 4'd0;
      x_q    <= '0;
      sym_q  <= 2'b00;
      lfsr_q <= LFSR_SEED;
`ifdef IMPULSE_MODE_EN
      sc_q   <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      sym_q  <= sym_d;
      lfsr_q <= lfsr_d;
`ifdef IMPULSE_MODE_EN
      sc_q   <= sc_d;
`endif
    end
  end

  assign sam_clk_en = (cnt_q[1:0] == 2'd3);
  assign sym_clk_en = (cnt_q == 4'd15);
  assign x_out      = x_q;
  assign sym_out    = sym_q;
  assign lfsr_state = lfsr_q;

endmodule
`default_nettype wire

// File: tb/tb_ask4_upsample_src.sv
`default_nettype none
// Self-checking bench for ask4_upsample_src: per-cycle comparison against a
// frame/symbol-index reference model, with randomized asynchronous resets.
module tb_ask4_upsample_src;

  localparam logic [21:0] SEED = 22'h3FFFFF;
  localparam int          MAG  = 32768;
  localparam int          NSYM = 256;

  logic               clk;
  logic               reset;
  logic               sam_clk_en;
  logic               sym_clk_en;
  logic signed [17:0] x_out;
  logic [1:0]         sym_out;
  logic [21:0]        lfsr_state;
`ifdef IMPULSE_MODE_EN
  logic               impulse_sel;
`endif

  int errors = 0;
  int checks = 0;
  int k;
  int unsigned lf [0:NSYM];

  ask4_upsample_src dut (
    .clk        (clk),
    .reset      (reset),
`ifdef IMPULSE_MODE_EN
    .impulse_sel(impulse_sel),
`endif
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .x_out      (x_out),
    .sym_out    (sym_out),
    .lfsr_state (lfsr_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned lstep(input int unsigned s);
    if (s == 0) return SEED;
    return ((s * 2) % (1 << 22)) + (((s >> 21) ^ (s >> 20)) & 1);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  // Expected outputs k rising edges after reset release.
  task automatic check_cycle();
    int ph, n, s, xe;
    int unsigned le;
    ph = k % 16;
    n  = (k >= 15) ? (k - 15) / 16 : -1;
    if (n < 0) begin
      s = 0; xe = 0; le = SEED;
    end else begin
      s  = int'(lf[n] % 4);
      xe = (ph == 15 || ph <= 2) ? (2 * s - 3) * MAG : 0;
      le = lf[n + 1];
    end
    check("sam_clk_en", 32'(sam_clk_en), ((k % 4) == 3) ? 1 : 0);
    check("sym_clk_en", 32'(sym_clk_en), (ph == 15) ? 1 : 0);
    check("x_out",      32'(x_out), xe);
    check("sym_out",    32'(sym_out), s);
    check("lfsr_state", 32'(lfsr_state), int'(le));
    if (k == 15) begin
      check("first_sym0", 32'(sym_out), 3);
      check("first_x0",   32'(x_out), 98304);
    end
    if (k == 31) begin
      check("first_sym1", 32'(sym_out), 2);
      check("first_x1",   32'(x_out), 32768);
    end
    if (k == 47) begin
      check("first_sym2", 32'(sym_out), 0);
      check("first_x2",   32'(x_out), -98304);
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  task automatic run_to_phase(input int ph);
    while ((k % 16) != ph) run_cycles(1);
  endtask

  // Assert reset asynchronously mid-cycle, verify immediate clear, release later.
  task automatic pulse_reset(input int hold);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sam",  32'(sam_clk_en), 0);
    check("rst_sym",  32'(sym_clk_en), 0);
    check("rst_x",    32'(x_out), 0);
    check("rst_symo", 32'(sym_out), 0);
    check("rst_lfsr", 32'(lfsr_state), int'(SEED));
    for (int i = 0; i < hold; i++) @(negedge clk);
    check("rst_hold_sam", 32'(sam_clk_en), 0);
    check("rst_hold_x",   32'(x_out), 0);
    reset = 1'b0;
    k = 0;
  endtask

  initial begin
    lf[0] = SEED;
    for (int i = 0; i < NSYM; i++) lf[i + 1] = lstep(lf[i]);

    reset = 1'b1;
    k = 0;
`ifdef IMPULSE_MODE_EN
    impulse_sel = 1'b0;
`endif
    #1;
    check("init_lfsr", 32'(lfsr_state), int'(SEED));
    check("init_x",    32'(x_out), 0);
    repeat (3) @(negedge clk);
    check("init_sam",  32'(sam_clk_en), 0);
    check("init_sym",  32'(sym_clk_en), 0);
    reset = 1'b0;

    run_cycles(1000);

    run_to_phase(9);
    pulse_reset(1);
    run_cycles(600);

    for (int r = 0; r < 4; r++) begin
      run_to_phase(int'($urandom_range(0, 15)));
      pulse_reset(int'($urandom_range(1, 4)));
      run_cycles(int'($urandom_range(200, 900)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
